v_mem_access_unit: RTL
======================

// Module: v_mem_access_unit
// PURPOSE
//  Vector memory responder. Accepts one decoded vector memory request
//  (VLE64/VSE64, VLX/VSX) from the vector decode stage and executes it as a
//  sequence of per-element 64-bit data-memory accesses. Loads are packed into
//  one VLEN-bit register image for writeback; stores write truncated lanes.
//  Sits between vector decode and the shared data-memory port.
// PARAMETERS
//  VLEN    512  vector register width, bits
//  ELEN    64   element/lane width, bits; NLANES = VLEN/ELEN = 8
//  MEM_AW  64   byte address width
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous active-high reset
//  req_valid    in   1       request present (decode ren|wen)
//  req_ready    out  1       1 only in IDLE
//  req_we       in   1       1 = store, 0 = load
//  req_is_ext   in   1       1 = VLX/VSX, 0 = VLE64/VSE64
//  req_addr     in   MEM_AW  base byte address, offset already added
//  req_width    in   3       000=8b 001=16b 010=32b 011=64b (ext only)
//  req_len      in   3       element count - 1 (ext only)
//  req_sign     in   1       VLX: 1 = sign-extend, 0 = zero-extend
//  req_wdata    in   VLEN    store source register image
//  req_vd       in   5       load destination register
//  mem_en       out  1       memory access this cycle
//  mem_we       out  1       write access
//  mem_addr     out  MEM_AW  8-byte-aligned word address
//  mem_wdata    out  ELEN    write data, byte-lane positioned
//  mem_wstrb    out  8       byte strobes
//  mem_rdata    in   ELEN    read data, valid the cycle after mem_en&&!mem_we
//  resp_valid   out  1       one-cycle completion pulse
//  resp_we      out  1       vreg write enable (successful load only)
//  resp_vd      out  5       destination register
//  resp_data    out  VLEN    packed load result
//  resp_err     out  1       request rejected
//  busy         out  1       !IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready=1; element counter 0;
//   resp_data cleared.
//  Accept on req_valid&&req_ready (cycle T); latch all req_* fields;
//   req_wdata may change after T. req_valid outside IDLE is ignored.
//  Non-ext: N=8, esize=8 bytes; req_width/len/sign ignored. Ext: N=len+1,
//   esize=1<<width.
//  Element i address a_i = base + i*esize; mem_addr = {a_i[63:3],3'b0};
//   byte offset o = a_i[2:0]; mem_wstrb = ((1<<esize)-1) << o;
//   mem_wdata = lane_i[esize*8-1:0] << (o*8).
//  Load lane i = (mem_rdata >> o*8) truncated to esize, sign/zero extended
//   to 64 b; lanes >= N are 0.
//  Error check at T: width 1xx, or base not aligned to esize -> no memory
//   access, RESP at T+1 with resp_err=1, resp_we=0.
//  FSM: IDLE -> RUN (accept, no error) | RESP (error).
//   RUN: issue element i each cycle, i=0..N-1; load captures element i-1
//    same cycle. Last issue -> DRAIN (load) or RESP (store).
//   DRAIN: capture element N-1, mem_en=0 -> RESP.
//   RESP: resp_valid=1 one cycle -> IDLE.
//  Latency: load resp_valid at T+N+2; store at T+N+1; error at T+1.
//  resp_we = !latched_we && !err; resp_vd = latched vd.
//  Ext base near word end: elements wrap into next word naturally via a_i.
//  Reset mid-operation: next cycle IDLE, mem_en=0, no resp_valid, partial
//   load data discarded; already-issued store writes are not undone.
// STRUCTURE
//  v_defines.v: VLEN, ELEN, width codes WIDTH_B/H/W/D, state encodings,
//   VMEM_ADDR_BUS/VMEM_DATA_BUS.
//  Sub-module v_mem_lane_fmt (combinational): {esize, o, sign, rdata/lane}
//   -> extended lane, positioned wdata, wstrb. Top keeps FSM, counter, packer.
// TESTING
//  VLE64 base 0x100, word k = 0x1111*k -> reads 0x100..0x138, resp T+10,
//   lane k = 0x1111*k, resp_we=1.
//  VLX width=000 len=3 sign=1 base 0x203, bytes 80,7F,FF,01 -> lanes
//   FFFF_FFFF_FFFF_FF80, 0x7F, all-ones, 0x01; lanes 4-7 = 0; resp T+6.
//  VSX width=001 len=1 base 0x10A, lanes 0xABCD,0x1234 -> addr 0x108
//   strb 0x0C wdata 0xABCD<<16, then 0x108 strb 0x30 0x1234<<32; resp T+3,
//   resp_we=0.
//  VLX width=010 base 0x106 -> no mem_en, resp T+1 err=1 we=0; width=101
//   same result.
//  Reset during RUN element 3 of VLE64 -> mem_en 0, req_ready 1 next cycle,
//   no resp_valid.
//  req_valid held over two loads -> second accepted cycle after RESP; each
//   resp_vd matches its request.

Source files
------------

// File: rtl/v_mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : v_mem_access_unit_pkg                                  |
// | Description : Shared constants, state encoding and helpers for the   |
// |               vector memory access unit.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package v_mem_access_unit_pkg;

  localparam int DEF_VLEN   = 512;
  localparam int DEF_ELEN   = 64;
  localparam int DEF_MEM_AW = 64;

  // Element width codes carried on req_width
  localparam logic [2:0] WIDTH_B = 3'b000;
  localparam logic [2:0] WIDTH_H = 3'b001;
  localparam logic [2:0] WIDTH_W = 3'b010;
  localparam logic [2:0] WIDTH_D = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Low address bits that must be zero for an element of 2**wlog bytes
  function automatic logic [2:0] align_mask(input logic [1:0] wlog);
    case (wlog)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  // Byte strobe pattern for an element of 2**wlog bytes at offset 0
  function automatic logic [7:0] size_strb(input logic [1:0] wlog);
    case (wlog)
      2'd0:    size_strb = 8'h01;
      2'd1:    size_strb = 8'h03;
      2'd2:    size_strb = 8'h0F;
      default: size_strb = 8'hFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/v_mem_lane_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : v_mem_lane_fmt                                         |
// | Description : Combinational lane formatter: extracts and extends a   |
// |               load element from a memory word, and positions a store |
// |               element plus its byte strobes within a memory word.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module v_mem_lane_fmt
  import v_mem_access_unit_pkg::*;
(
  input  logic [1:0]  esz_log,
  input  logic [2:0]  off,
  input  logic        sign,
  input  logic [63:0] rdata,
  input  logic [63:0] lane,
  output logic [63:0] ext_lane,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb
);

  logic [63:0] shifted;
  logic [63:0] trunc;

  // Load extraction with sign/zero extension; store truncation and placement
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (esz_log)
      2'd0: begin
        ext_lane = {{56{sign & shifted[7]}}, shifted[7:0]};
        trunc    = {56'b0, lane[7:0]};
      end
      2'd1: begin
        ext_lane = {{48{sign & shifted[15]}}, shifted[15:0]};
        trunc    = {48'b0, lane[15:0]};
      end
      2'd2: begin
        ext_lane = {{32{sign & shifted[31]}}, shifted[31:0]};
        trunc    = {32'b0, lane[31:0]};
      end
      default: begin
        ext_lane = shifted;
        trunc    = lane;
      end
    endcase
    wdata = trunc << {off, 3'b000};
    wstrb = size_strb(esz_log) << off;
  end

endmodule
`default_nettype wire

// File: rtl/v_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : v_mem_access_unit                                      |
// | Description : Vector memory responder. Runs one unit-stride or       |
// |               indexed-width vector load/store as a sequence of       |
// |               64-bit memory accesses and returns a packed result.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module v_mem_access_unit
  import v_mem_access_unit_pkg::*;
#(
  parameter int VLEN   = DEF_VLEN,
  parameter int ELEN   = DEF_ELEN,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_is_ext,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [2:0]        req_width,
  input  logic [2:0]        req_len,
  input  logic              req_sign,
  input  logic [VLEN-1:0]   req_wdata,
  input  logic [4:0]        req_vd,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [ELEN-1:0]   mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic [ELEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [4:0]        resp_vd,
  output logic [VLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;       // next element to issue (reaches N)
  logic              we_q, we_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [1:0]        wlog_q, wlog_d;     // log2 of element size in bytes
  logic [2:0]        last_q, last_d;     // index of final element
  logic              sign_q, sign_d;
  logic [4:0]        vd_q, vd_d;
  logic              err_q, err_d;
  logic [VLEN-1:0]   wdata_q, wdata_d;
  logic [VLEN-1:0]   data_q, data_d;
  logic [2:0]        rd_off_q, rd_off_d; // byte offset of the element in flight

  logic [1:0]        req_wlog;
  logic              req_bad;
  logic [MEM_AW-1:0] elem_addr;
  logic [2:0]        cur_off;
  logic [2:0]        cap_idx;
  logic [ELEN-1:0]   cur_lane;
  logic [ELEN-1:0]   fmt_ext;
  logic [ELEN-1:0]   fmt_wdata;
  logic [7:0]        fmt_wstrb;

  // Request decode, current element address and store lane selection
  always_comb begin
    req_wlog  = req_is_ext ? req_width[1:0] : 2'd3;
    req_bad   = (req_is_ext && req_width[2]) ||
                ((req_addr[2:0] & align_mask(req_wlog)) != 3'b000);
    elem_addr = base_q + (MEM_AW'(idx_q) << wlog_q);
    cur_off   = elem_addr[2:0];
    cap_idx   = idx_q[2:0] - 3'd1;
    cur_lane  = wdata_q[idx_q[2:0]*ELEN +: ELEN];
  end

  // Stores format the element being issued; loads format the returning one
  v_mem_lane_fmt u_fmt (
    .esz_log  (wlog_q),
    .off      (we_q ? cur_off : rd_off_q),
    .sign     (sign_q),
    .rdata    (mem_rdata),
    .lane     (cur_lane),
    .ext_lane (fmt_ext),
    .wdata    (fmt_wdata),
    .wstrb    (fmt_wstrb)
  );

  // Next-state, datapath updates and outputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    we_d       = we_q;
    base_d     = base_q;
    wlog_d     = wlog_q;
    last_d     = last_q;
    sign_d     = sign_q;
    vd_d       = vd_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    rd_off_d   = rd_off_q;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    resp_valid = 1'b0;
    resp_we    = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          base_d  = req_addr;
          wlog_d  = req_wlog;
          last_d  = req_is_ext ? req_len : 3'd7;
          sign_d  = req_is_ext & req_sign;
          vd_d    = req_vd;
          err_d   = req_bad;
          wdata_d = req_wdata;
          data_d  = '0;
          idx_d   = '0;
          state_d = req_bad ? ST_RESP : ST_RUN;
        end
      end
      ST_RUN: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = {elem_addr[MEM_AW-1:3], 3'b000};
        if (we_q) begin
          mem_wdata = fmt_wdata;
          mem_wstrb = fmt_wstrb;
        end else if (idx_q != 4'd0) begin
          data_d[cap_idx*ELEN +: ELEN] = fmt_ext;
        end
        rd_off_d = cur_off;
        idx_d    = idx_q + 4'd1;
        if (idx_q[2:0] == last_q) begin
          state_d = we_q ? ST_RESP : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        data_d[cap_idx*ELEN +: ELEN] = fmt_ext;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_we    = !we_q && !err_q;
        resp_err   = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy      = (state_q != ST_IDLE);
    resp_vd   = vd_q;
    resp_data = data_q;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      we_q     <= 1'b0;
      base_q   <= '0;
      wlog_q   <= '0;
      last_q   <= '0;
      sign_q   <= 1'b0;
      vd_q     <= '0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      data_q   <= '0;
      rd_off_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      base_q   <= base_d;
      wlog_q   <= wlog_d;
      last_q   <= last_d;
      sign_q   <= sign_d;
      vd_q     <= vd_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      rd_off_q <= rd_off_d;
    end
  end

endmodule
`default_nettype wire
